// File: rtl/test_status_dev_if.sv
// Core data-bus slice seen by the test-status device: request, address, data, acknowledge.
// Latency: none (wires only).
// Backpressure: none; the slave acknowledges every selected access one cycle later.
//
// Ports: we_i/re_i/addr_i/wdata_i driven by the core (master); rdata_o/ready_o by the device (slave).
interface test_status_dev_if;
  logic        we_i;
  logic        re_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ready_o;

  modport master (
    output we_i, re_i, addr_i, wdata_i,
    input  rdata_o, ready_o
  );

  modport slave (
    input  we_i, re_i, addr_i, wdata_i,
    output rdata_o, ready_o
  );
endinterface

// File: rtl/test_status_dev.sv
// Memory-mapped test-status device: tracks a self-test run (IDLE/RUN/PASS/FAIL/TMO) reported by software.
// Latency: every selected access is acknowledged exactly one cycle later with registered read data.
// Backpressure: none; a new access is accepted every cycle, ready_o stays high for back-to-back accesses.
//
// Ports: clk, rst (async active-low); bus (slave side of test_status_dev_if);
//        done_o/pass_o/fail_o test outcome, testnum_o last reported test, cycles_o cycles spent in RUN.
module test_status_dev #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
  input  logic                    clk,
  input  logic                    rst,
  test_status_dev_if.slave        bus,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic [31:0]             testnum_o,
  output logic [31:0]             cycles_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  localparam logic [1:0] OFF_TOHOST  = 2'd0;
  localparam logic [1:0] OFF_TESTNUM = 2'd1;
  localparam logic [1:0] OFF_CYCLES  = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  state_t      state_q,   state_d;
  logic        ready_q,   ready_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [31:0] testnum_q, testnum_d;
  logic [31:0] cycles_q,  cycles_d;
  logic        done_q,    done_d;
  logic        pass_q,    pass_d;
  logic        fail_q,    fail_d;

  logic        sel;
  logic        acc;
  logic        wr;
  logic        rd;
  logic [1:0]  off;
  logic        wr_live;
  logic [31:0] cycles_inc;
  logic        unused_addr_lsb;

  // Byte lanes are irrelevant: every register is a full word.
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign sel = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign acc = sel & (bus.we_i | bus.re_i);
  // A simultaneous read+write is treated as a write; no read data is returned.
  assign wr  = acc & bus.we_i;
  assign rd  = acc & bus.re_i & ~bus.we_i;
  assign off = bus.addr_i[3:2];

  // Writes only take effect before the outcome is latched; IDLE writes also
  // act immediately because the first access is what starts the run.
  assign wr_live = wr & ((state_q == ST_IDLE) | (state_q == ST_RUN));

  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    testnum_d = testnum_q;
    cycles_d  = cycles_q;
    ready_d   = acc;
    rdata_d   = 32'd0;

    if (rd) begin
      case (off)
        OFF_TESTNUM: rdata_d = testnum_q;
        OFF_CYCLES:  rdata_d = cycles_q;
        OFF_STATUS:  rdata_d = {29'd0,
                                (state_q == ST_TMO),
                                (state_q == ST_FAIL) | (state_q == ST_TMO),
                                (state_q == ST_PASS)};
        default:     rdata_d = 32'd0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (acc) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycles_d = cycles_inc;
        if ((TIMEOUT_CYC != 32'd0) && (cycles_inc == TIMEOUT_CYC)) state_d = ST_TMO;
      end
      default: ;
    endcase

    // A decisive TOHOST write overrides a timeout landing on the same edge.
    if (wr_live) begin
      case (off)
        OFF_TOHOST: begin
          if (bus.wdata_i == 32'd1) begin
            state_d = ST_PASS;
          end else if (bus.wdata_i[0]) begin
            state_d   = ST_FAIL;
            testnum_d = {1'b0, bus.wdata_i[31:1]};
          end
        end
        OFF_TESTNUM: testnum_d = bus.wdata_i;
        default: ;
      endcase
    end

    // Outcome flags are flopped from the next state so they come straight off registers.
    done_d = (state_d == ST_PASS) | (state_d == ST_FAIL) | (state_d == ST_TMO);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL) | (state_d == ST_TMO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      testnum_q <= 32'd0;
      cycles_q  <= 32'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      testnum_q <= testnum_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.rdata_o = rdata_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign testnum_o   = testnum_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_test_status_dev.sv
// Bench for test_status_dev: two instances (default timeout, and TIMEOUT_CYC=20) share one stimulus stream.
// Expected bus responses are queued when an access is driven and checked when the acknowledge cycle arrives.
// Outputs are sampled 1 time unit after each rising edge.
module tb_test_status_dev;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct packed {
    logic        rdy;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        done_a, pass_a, fail_a;
  logic [31:0] testnum_a, cycles_a;
  logic        done_b, pass_b, fail_b;
  logic [31:0] testnum_b, cycles_b;

  exp_t sb[$];
  exp_t e;
  int   n_tests;
  int   n_fail;

  test_status_dev_if bus_a ();
  test_status_dev_if bus_b ();

  assign bus_a.we_i    = we;
  assign bus_a.re_i    = re;
  assign bus_a.addr_i  = addr;
  assign bus_a.wdata_i = wdata;
  assign bus_b.we_i    = we;
  assign bus_b.re_i    = re;
  assign bus_b.addr_i  = addr;
  assign bus_b.wdata_i = wdata;

  test_status_dev #(.BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
    .testnum_o(testnum_a), .cycles_o(cycles_a)
  );

  test_status_dev #(.BASE_ADDR(BASE), .TIMEOUT_CYC(32'd20)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
    .testnum_o(testnum_b), .cycles_o(cycles_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1);
  end

  function automatic exp_t mk(input logic r, input logic [31:0] d);
    exp_t t;
    t.rdy = r;
    t.rd  = d;
    return t;
  endfunction

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus_a.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus_a.ready_o); end
    n_tests++; if (bus_a.rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus_a.rdata_o); end
    n_tests++; if ({done_a, pass_a, fail_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {done_a, pass_a, fail_a}); end
    n_tests++; if (testnum_a !== 32'd0) begin n_fail++; $display("FAIL reset_testnum got %h want 0", testnum_a); end
    step(0, 0, 32'd0, 32'd0);
    n_tests++; if (cycles_a !== 32'd0) begin n_fail++; $display("FAIL reset_idle_cycles got %0d want 0", cycles_a); end
  endtask

  task automatic test_pass();
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE + 32'h4, 32'd5);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL pass_wr_testnum_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    n_tests++; if (testnum_a !== 32'd5 || done_a !== 1'b0) begin n_fail++; $display("FAIL pass_testnum got %0d done %b want 5 done 0", testnum_a, done_a); end
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE, 32'd1);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL pass_wr_tohost_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    n_tests++; if ({done_a, pass_a, fail_a} !== 3'b110) begin n_fail++; $display("FAIL pass_flags got %b want 110", {done_a, pass_a, fail_a}); end
    n_tests++; if (testnum_a !== 32'd5) begin n_fail++; $display("FAIL pass_testnum_kept got %0d want 5", testnum_a); end
    sb.push_back(mk(1'b0, 32'd0));
    step(0, 0, 32'd0, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy) begin n_fail++; $display("FAIL pass_ready_drop got %b want %b", bus_a.ready_o, e.rdy); end
    // Terminal: write still acknowledged but ignored; cycles frozen at 1 (incremented on the PASS edge).
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE + 32'h4, 32'd99);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || testnum_a !== 32'd5) begin n_fail++; $display("FAIL pass_terminal_write got rdy %b testnum %0d want 1 5", bus_a.ready_o, testnum_a); end
    repeat (3) step(0, 0, 32'd0, 32'd0);
    n_tests++; if (cycles_a !== 32'd1) begin n_fail++; $display("FAIL pass_cycles_frozen got %0d want 1", cycles_a); end
  endtask

  task automatic test_fail();
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE, 32'h7);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL fail_wr_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    n_tests++; if ({done_a, pass_a, fail_a} !== 3'b101) begin n_fail++; $display("FAIL fail_flags got %b want 101", {done_a, pass_a, fail_a}); end
    n_tests++; if (testnum_a !== 32'd3) begin n_fail++; $display("FAIL fail_testnum got %0d want 3", testnum_a); end
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE, 32'd1);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || {pass_a, fail_a} !== 2'b01) begin n_fail++; $display("FAIL fail_sticky got rdy %b pass/fail %b want 1 01", bus_a.ready_o, {pass_a, fail_a}); end
    sb.push_back(mk(1'b1, 32'h2));
    step(0, 1, BASE + 32'hC, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL fail_status got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
  endtask

  task automatic test_timeout();
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(0, 1, BASE + 32'h8, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_b.ready_o !== e.rdy || bus_b.rdata_o !== e.rd) begin n_fail++; $display("FAIL tmo_enter_ack got %b/%h want %b/%h", bus_b.ready_o, bus_b.rdata_o, e.rdy, e.rd); end
    repeat (19) step(0, 0, 32'd0, 32'd0);
    n_tests++; if (done_b !== 1'b0 || cycles_b !== 32'd19) begin n_fail++; $display("FAIL tmo_before got done %b cycles %0d want 0 19", done_b, cycles_b); end
    step(0, 0, 32'd0, 32'd0);
    n_tests++; if ({done_b, pass_b, fail_b} !== 3'b101 || cycles_b !== 32'd20) begin n_fail++; $display("FAIL tmo_hit got flags %b cycles %0d want 101 20", {done_b, pass_b, fail_b}, cycles_b); end
    sb.push_back(mk(1'b1, 32'h6));
    step(0, 1, BASE + 32'hC, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_b.ready_o !== e.rdy || bus_b.rdata_o !== e.rd) begin n_fail++; $display("FAIL tmo_status got %b/%h want %b/%h", bus_b.ready_o, bus_b.rdata_o, e.rdy, e.rd); end
    n_tests++; if (cycles_b !== 32'd20) begin n_fail++; $display("FAIL tmo_cycles_frozen got %0d want 20", cycles_b); end
  endtask

  task automatic test_cycles_decode();
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(0, 1, BASE + 32'h8, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL cyc_enter_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    repeat (10) step(0, 0, 32'd0, 32'd0);
    n_tests++; if (cycles_a !== 32'd10) begin n_fail++; $display("FAIL cyc_count got %0d want 10", cycles_a); end
    sb.push_back(mk(1'b1, 32'd10));
    step(0, 1, BASE + 32'h8, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL cyc_read got %b/%0d want %b/%0d", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    n_tests++; if (cycles_a !== 32'd11) begin n_fail++; $display("FAIL cyc_after_read got %0d want 11", cycles_a); end
    sb.push_back(mk(1'b0, 32'd0));
    step(0, 1, BASE + 32'h20, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL cyc_unsel_read got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    sb.push_back(mk(1'b0, 32'd0));
    step(1, 0, BASE + 32'h20, 32'd1);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || pass_a !== 1'b0) begin n_fail++; $display("FAIL cyc_unsel_write got rdy %b pass %b want 0 0", bus_a.ready_o, pass_a); end
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE + 32'h7, 32'd9);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || testnum_a !== 32'd9) begin n_fail++; $display("FAIL cyc_lsb_ignored got rdy %b testnum %0d want 1 9", bus_a.ready_o, testnum_a); end
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE, 32'd4);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || done_a !== 1'b0) begin n_fail++; $display("FAIL cyc_even_tohost got rdy %b done %b want 1 0", bus_a.ready_o, done_a); end
  endtask

  task automatic test_back_to_back();
    logic        t_we [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_off[5] = '{32'h4, 32'h4, 32'hC, 32'h8, 32'h0};
    logic [31:0] t_wd [5] = '{32'hA5, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] t_exp[5] = '{32'd0, 32'hA5, 32'd0, 32'd2, 32'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(1'b1, t_exp[i]));
      step(t_we[i], ~t_we[i], BASE + t_off[i], t_wd[i]);
      e = sb.pop_front();
      n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL b2b_access%0d got %b/%h want %b/%h", i, bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    end
    sb.push_back(mk(1'b0, 32'd0));
    step(0, 0, 32'd0, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy) begin n_fail++; $display("FAIL b2b_ready_drop got %b want %b", bus_a.ready_o, e.rdy); end
  endtask

  task automatic test_we_re_and_async_reset();
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 1, BASE, 32'd1);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL wr_rd_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL wr_rd_pass got %b want 1", pass_a); end
    do_reset();
    sb.push_back(mk(1'b1, 32'd0));
    step(0, 1, BASE, 32'd0);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || bus_a.rdata_o !== e.rd) begin n_fail++; $display("FAIL arst_enter_ack got %b/%h want %b/%h", bus_a.ready_o, bus_a.rdata_o, e.rdy, e.rd); end
    sb.push_back(mk(1'b1, 32'd0));
    step(1, 0, BASE + 32'h4, 32'd7);
    e = sb.pop_front();
    n_tests++; if (bus_a.ready_o !== e.rdy || testnum_a !== 32'd7 || cycles_a !== 32'd1) begin n_fail++; $display("FAIL arst_pre got rdy %b testnum %0d cycles %0d want 1 7 1", bus_a.ready_o, testnum_a, cycles_a); end
    // Assert reset between edges: outputs must clear with no clock edge.
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if ({bus_a.ready_o, done_a, pass_a, fail_a} !== 4'b0000 || bus_a.rdata_o !== 32'd0) begin n_fail++; $display("FAIL arst_flags got rdy/done/pass/fail %b rdata %h want 0000 0", {bus_a.ready_o, done_a, pass_a, fail_a}, bus_a.rdata_o); end
    n_tests++; if (testnum_a !== 32'd0 || cycles_a !== 32'd0) begin n_fail++; $display("FAIL arst_regs got testnum %0d cycles %0d want 0 0", testnum_a, cycles_a); end
    we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 32'd0, 32'd0);
    n_tests++; if ({bus_a.ready_o, done_a, fail_a} !== 3'b000 || cycles_a !== 32'd0) begin n_fail++; $display("FAIL arst_release got rdy/done/fail %b cycles %0d want 000 0", {bus_a.ready_o, done_a, fail_a}, cycles_a); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_cycles_decode();
    test_back_to_back();
    test_we_re_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_status_dev.md
TEST_STATUS_DEV -- requirements
Module: test_status_dev

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, word-aligned base of the 16-byte register window.
REQ-002 Parameter TIMEOUT_CYC, default 32'd100000, RUN-state cycle limit before timeout; 0 disables timeout.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 we_i  input  1  write request from core data bus.
REQ-006 re_i  input  1  read request from core data bus.
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  32  write data.
REQ-009 rdata_o  output  32  read data, valid while ready_o=1.
REQ-010 ready_o  output  1  one-cycle access acknowledge.
REQ-011 done_o  output  1  test finished (PASS, FAIL or TIMEOUT).
REQ-012 pass_o  output  1  test passed.
REQ-013 fail_o  output  1  test failed or timed out.
REQ-014 testnum_o  output  32  last reported test number.
REQ-015 cycles_o  output  32  cycles spent in RUN.

Function
REQ-016 Register map (offset from BASE_ADDR): 0x0 TOHOST (W), 0x4 TESTNUM (R/W), 0x8 CYCLES (R), 0xC STATUS (R) = {29'b0, timeout, fail, pass}.
REQ-017 Access selected only when addr_i[31:4]==BASE_ADDR[31:4]; addr_i[1:0] ignored; non-selected accesses: no state change, no ready_o.
REQ-018 Selected access in cycle N -> ready_o=1 exactly in cycle N+1, registered; rdata_o registered in the same edge, 0 when ready_o=0 or on a write.
REQ-019 we_i and re_i both high on a selected address -> handled as write only; rdata_o=0.
REQ-020 Back-to-back accesses are accepted every cycle; ready_o stays high for consecutive accepted accesses.
REQ-021 FSM states: IDLE, RUN, PASS, FAIL, TMO; reset state IDLE.
REQ-022 IDLE -> RUN on first selected access of any kind (core is executing).
REQ-023 RUN: write TOHOST value 1 -> PASS; odd value !=1 -> FAIL with testnum_o = wdata_i>>1; even value -> no transition.
REQ-024 RUN: write TESTNUM -> testnum_o = wdata_i, state unchanged.
REQ-025 RUN: cycles_o increments by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-026 RUN: when TIMEOUT_CYC!=0 and cycles_o reaches TIMEOUT_CYC -> TMO on that edge; a TOHOST write in the same cycle takes priority over timeout.
REQ-027 PASS, FAIL, TMO are terminal: all further writes ignored (ready_o still returned), cycles_o frozen, only reset exits.
REQ-028 Outputs: done_o = state in {PASS,FAIL,TMO}; pass_o = PASS; fail_o = FAIL or TMO; all decoded from state register, glitch-free.
REQ-029 Write in IDLE: transitions to RUN and also performs the RUN write action in that same cycle.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, ready_o=0, rdata_o=0, testnum_o=0, cycles_o=0, hence done_o=pass_o=fail_o=0.
REQ-031 rst asserted mid-RUN or in a terminal state discards all results; no output pulse generated on deassertion.
REQ-032 Outputs stable from the first rising edge after rst deasserts.

Verification
REQ-033 Reset, write TESTNUM=5, write TOHOST=1 -> ready_o pulses each next cycle, pass_o=1, done_o=1, testnum_o=5.
REQ-034 Write TOHOST=32'h7 -> fail_o=1, pass_o=0, testnum_o=3; subsequent TOHOST=1 -> still fail_o=1.
REQ-035 TIMEOUT_CYC=20, single read to enter RUN, no writes -> done_o=1, fail_o=1, STATUS read returns 3'b110 at 20 cycles.
REQ-036 Read CYCLES after 10 RUN cycles -> rdata_o equals cycles_o at access edge; access to BASE_ADDR+0x20 -> no ready_o.
REQ-037 we_i=re_i=1 to TOHOST=1 -> pass_o=1, rdata_o=0; rst low mid-RUN -> all outputs 0 immediately, without a clock edge.
